// File: rtl/usb_host_tx_if.sv
// Byte stream from the packet source plus the driven D+/D- line, shared between
// the packet source (master) and the USB host line transmitter (slave).
interface usb_host_tx_if;
    typedef struct packed {
        logic p;
        logic n;
    } d_port_t;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    d_port_t    d_o;
    logic       d_en;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  d_o,
        input  d_en
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output d_o,
        output d_en
    );
endinterface

// File: rtl/usb_host_tx.sv
// USB host line transmitter: SYNC + NRZI/bit-stuffed bytes + EOP at full or low
// speed, plus host bus reset (long SE0) and low-speed keep-alive EOPs.
module usb_host_tx #(
    parameter int CLK_DIV_FS   = 4,
    parameter int CLK_DIV_LS   = 32,
    parameter int RESET_CYCLES = 480000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         usb_full_speed,
    usb_host_tx_if.slave bus,
    input  logic         bus_reset_req,
    input  logic         keep_alive_req,
    output logic         busy
);
    localparam int DIV_MAX = (CLK_DIV_LS > CLK_DIV_FS) ? CLK_DIV_LS : CLK_DIV_FS;
    localparam int TW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int RW      = $clog2(RESET_CYCLES + 1);
    localparam logic [TW-1:0] FS_LAST  = TW'(CLK_DIV_FS - 1);
    localparam logic [TW-1:0] LS_LAST  = TW'(CLK_DIV_LS - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, SYNC, DATA, EOP_SE0, EOP_J, BUS_RST, RST_J, KA_SE0, KA_J
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    byte_r, byte_n;
    logic          stuffing, stuffing_n;
    logic [2:0]    ones, ones_n;
    logic          lvl_k, lvl_k_n;
    logic          fs, fs_n;
    logic [RW-1:0] rst_cnt, rst_cnt_n;
    logic          rst_pend, rst_pend_n;
    logic          ka_pend, ka_pend_n;
    logic          line_up;
    logic          ready_c;
    logic          send, send_val;
    logic          bit_end;
    logic [1:0]    line;

    function automatic logic [1:0] j_of(input logic full);
        return full ? 2'b10 : 2'b01;
    endfunction

    assign bit_end = (timer == (fs ? FS_LAST : LS_LAST));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_n    = state;
        timer_n    = '0;
        bit_cnt_n  = bit_cnt;
        byte_n     = byte_r;
        stuffing_n = stuffing;
        ones_n     = ones;
        lvl_k_n    = lvl_k;
        fs_n       = fs;
        rst_cnt_n  = rst_cnt;
        rst_pend_n = rst_pend | bus_reset_req;
        ka_pend_n  = ka_pend | keep_alive_req;
        ready_c    = 1'b0;
        send       = 1'b0;
        send_val   = 1'b0;
        if (state != IDLE && !bit_end) timer_n = timer + TW'(1);

        unique case (state)
            IDLE: begin
                fs_n      = usb_full_speed;
                bit_cnt_n = '0;
                rst_cnt_n = '0;
                if (rst_pend_n) begin
                    state_n    = BUS_RST;
                    rst_pend_n = 1'b0;
                end else if (bus.tx_valid) begin
                    ready_c    = 1'b1;
                    byte_n     = bus.tx_data;
                    ones_n     = '0;
                    stuffing_n = 1'b0;
                    lvl_k_n    = 1'b1;  // first SYNC bit is a 0: idle J toggles to K
                    state_n    = SYNC;
                end else if (ka_pend_n) begin
                    state_n   = KA_SE0;
                    ka_pend_n = 1'b0;
                end
            end
            SYNC: if (bit_end) begin
                send = 1'b1;
                if (bit_cnt == 3'd7) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    send_val  = byte_r[0];
                end else begin
                    bit_cnt_n = bit_cnt + 3'd1;
                    send_val  = (bit_cnt == 3'd6);
                end
            end
            DATA: if (bit_end) begin
                if (!stuffing && ones == 3'd6) begin
                    stuffing_n = 1'b1;
                    ones_n     = '0;
                    lvl_k_n    = ~lvl_k;
                end else begin
                    stuffing_n = 1'b0;
                    if (bit_cnt != 3'd7) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        send      = 1'b1;
                        send_val  = byte_r[bit_cnt + 3'd1];
                    end else if (bus.tx_valid) begin
                        ready_c   = 1'b1;
                        byte_n    = bus.tx_data;
                        bit_cnt_n = '0;
                        send      = 1'b1;
                        send_val  = bus.tx_data[0];
                    end else begin
                        state_n   = EOP_SE0;
                        bit_cnt_n = '0;
                    end
                end
            end
            EOP_SE0, KA_SE0: if (bit_end) begin
                if (bit_cnt == 3'd1) begin
                    state_n   = (state == EOP_SE0) ? EOP_J : KA_J;
                    bit_cnt_n = '0;
                end else begin
                    bit_cnt_n = bit_cnt + 3'd1;
                end
            end
            BUS_RST: begin
                rst_cnt_n = rst_cnt + RW'(1);
                if (rst_cnt == RST_LAST) state_n = RST_J;
            end
            EOP_J, RST_J, KA_J: if (bit_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // NRZI: a 0 toggles the line, a 1 holds it and extends the run of ones
        if (send) begin
            ones_n  = send_val ? ones + 3'd1 : 3'd0;
            lvl_k_n = send_val ? lvl_k : ~lvl_k;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            byte_r   <= '0;
            stuffing <= 1'b0;
            ones     <= '0;
            lvl_k    <= 1'b0;
            fs       <= 1'b0;
            rst_cnt  <= '0;
            rst_pend <= 1'b0;
            ka_pend  <= 1'b0;
            line_up  <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            state    <= state_n;
            timer    <= timer_n;
            bit_cnt  <= bit_cnt_n;
            byte_r   <= byte_n;
            stuffing <= stuffing_n;
            ones     <= ones_n;
            lvl_k    <= lvl_k_n;
            fs       <= fs_n;
            rst_cnt  <= rst_cnt_n;
            rst_pend <= rst_pend_n;
            ka_pend  <= ka_pend_n;
            line_up  <= 1'b1;
        end
    end

    always_comb begin
        line = 2'b00;
        unique case (state)
            IDLE:               line = line_up ? j_of(usb_full_speed) : 2'b00;
            SYNC, DATA:         line = lvl_k ? ~j_of(fs) : j_of(fs);
            EOP_J, RST_J, KA_J: line = j_of(fs);
            default:            line = 2'b00;
        endcase
    end

    assign bus.d_o      = line;
    assign bus.d_en     = (state != IDLE);
    assign bus.tx_ready = ready_c & reset;
    assign busy         = (state != IDLE);
endmodule

// File: tb/tb_usb_host_tx.sv
// Self-checking bench for usb_host_tx: table-driven packets, hand-written reset,
// keep-alive and abort sequences, and randomized packets against a bit-level model.
module tb_usb_host_tx;
    localparam int FS_DIV  = 4;
    localparam int LS_DIV  = 32;
    localparam int RST_CYC = 100;

    logic clk = 1'b0;
    logic reset;
    logic usb_full_speed;
    logic bus_reset_req;
    logic keep_alive_req;
    logic busy;

    usb_host_tx_if bus_if();

    usb_host_tx #(
        .CLK_DIV_FS  (FS_DIV),
        .CLK_DIV_LS  (LS_DIV),
        .RESET_CYCLES(RST_CYC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .usb_full_speed(usb_full_speed),
        .bus           (bus_if),
        .bus_reset_req (bus_reset_req),
        .keep_alive_req(keep_alive_req),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [4:0] exp_q[$];     // per clk: {d_en, d_o, tx_ready, busy}
    logic [7:0] byte_q[$];
    logic [7:0] pkt[$];
    logic [1:0] line_log[$];
    int         rdy_at[$];
    int         en_clks, rdy_cnt, se0_clks;

    typedef struct {
        bit         fs;
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        int         en_clks;
        int         readies;
    } vec_t;

    vec_t vecs[5];

    logic [1:0] t1_sym[19] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01,
                               2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01,
                               2'b00, 2'b00, 2'b10};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [1:0] j_sym(input bit fs);
        return fs ? 2'b10 : 2'b01;
    endfunction

    function automatic int div_of(input bit fs);
        return fs ? FS_DIV : LS_DIV;
    endfunction

    task automatic m_start(input bit fs, input bit rdy);
        exp_q.push_back({1'b0, j_sym(fs), rdy, 1'b0});
    endtask

    task automatic m_hold(input logic [1:0] sym, input int clks);
        repeat (clks) exp_q.push_back({1'b1, sym, 1'b0, 1'b1});
    endtask

    task automatic m_idle(input bit fs);
        exp_q.push_back({1'b0, j_sym(fs), 1'b0, 1'b0});
    endtask

    // Packet model: build the line bit list (SYNC, stuffed data), then NRZI and expand to clocks.
    task automatic m_packet(input bit fs);
        bit   bits[$];
        int   last[$];
        int   ones;
        bit   v;
        bit   rdy;
        bit   lvl_k;
        int   div;
        div   = div_of(fs);
        ones  = 1;
        lvl_k = 1'b0;
        for (int i = 0; i < 8; i++) bits.push_back(i == 7);
        foreach (pkt[k]) begin
            for (int j = 0; j < 8; j++) begin
                v = pkt[k][j];
                bits.push_back(v);
                ones = v ? ones + 1 : 0;
                if (ones == 6) begin
                    bits.push_back(1'b0);
                    ones = 0;
                end
            end
            last.push_back(bits.size() - 1);
        end
        m_start(fs, 1'b1);
        for (int i = 0; i < bits.size(); i++) begin
            if (!bits[i]) lvl_k = ~lvl_k;
            for (int c = 0; c < div; c++) begin
                rdy = 1'b0;
                for (int k = 0; k < last.size() - 1; k++)
                    if (last[k] == i && c == div - 1) rdy = 1'b1;
                exp_q.push_back({1'b1, lvl_k ? ~j_sym(fs) : j_sym(fs), rdy, 1'b1});
            end
        end
        m_hold(2'b00, 2 * div);
        m_hold(j_sym(fs), div);
    endtask

    task automatic m_ka(input bit fs);
        m_start(fs, 1'b0);
        m_hold(2'b00, 2 * div_of(fs));
        m_hold(j_sym(fs), div_of(fs));
    endtask

    task automatic m_rst(input bit fs);
        m_start(fs, 1'b0);
        m_hold(2'b00, RST_CYC);
        m_hold(j_sym(fs), div_of(fs));
    endtask

    // Called just after a posedge with the DUT idle; cycle 0 is the deciding IDLE cycle.
    task automatic run(input int ka_at, input int rst_at);
        en_clks  = 0;
        rdy_cnt  = 0;
        se0_clks = 0;
        line_log.delete();
        rdy_at.delete();
        for (int c = 0; c < exp_q.size(); c++) begin
            bus_if.tx_valid = (byte_q.size() != 0);
            bus_if.tx_data  = (byte_q.size() != 0) ? byte_q[0] : 8'h00;
            keep_alive_req  = (c == ka_at);
            bus_reset_req   = (c == rst_at);
            @(negedge clk);
            check($sformatf("cycle %0d", c),
                  {27'd0, bus_if.d_en, bus_if.d_o, bus_if.tx_ready, busy}, {27'd0, exp_q[c]});
            line_log.push_back(bus_if.d_o);
            if (bus_if.d_en) en_clks++;
            if (bus_if.d_en && bus_if.d_o == 2'b00) se0_clks++;
            if (bus_if.tx_ready) begin
                rdy_cnt++;
                rdy_at.push_back(c);
                if (byte_q.size() != 0) void'(byte_q.pop_front());
            end
            @(posedge clk);
            #1;
        end
        bus_if.tx_valid = 1'b0;
        keep_alive_req  = 1'b0;
        bus_reset_req   = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit rfs;
        int rn;
        int pick;
        int ka_at;

        vecs[0] = '{1'b1, 1, 8'hA5, 8'h00, 76, 1};
        vecs[1] = '{1'b1, 2, 8'hFF, 8'h00, 112, 2};
        vecs[2] = '{1'b0, 1, 8'hA5, 8'h00, 608, 1};
        vecs[3] = '{1'b1, 1, 8'hFF, 8'h00, 80, 1};
        vecs[4] = '{1'b1, 2, 8'h00, 8'hFC, 112, 2};

        // Reset state, with tx_valid already asserted
        reset           = 1'b0;
        usb_full_speed  = 1'b1;
        bus_reset_req   = 1'b0;
        keep_alive_req  = 1'b0;
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs", {bus_if.d_en, bus_if.d_o, bus_if.tx_ready, busy}, 5'b0);
        @(posedge clk);
        #1;
        reset           = 1'b1;
        bus_if.tx_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle J fs", bus_if.d_o, 2'b10);
        usb_full_speed = 1'b0;
        #1;
        check("idle J ls", bus_if.d_o, 2'b01);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            usb_full_speed = vecs[i].fs;
            pkt.delete();
            pkt.push_back(vecs[i].b0);
            if (vecs[i].n > 1) pkt.push_back(vecs[i].b1);
            byte_q = pkt;
            m_packet(vecs[i].fs);
            m_idle(vecs[i].fs);
            run(-1, -1);
            check($sformatf("vec%0d d_en clks", i), en_clks, vecs[i].en_clks);
            check($sformatf("vec%0d tx_ready pulses", i), rdy_cnt, vecs[i].readies);
            if (i == 0) begin
                for (int s = 0; s < 19; s++)
                    check($sformatf("A5 line bit %0d", s), line_log[1 + 4 * s + 2], t1_sym[s]);
                check("A5 ready cycle", rdy_at[0], 0);
            end
            if (i == 1) check("FF00 second ready", rdy_at[1], 17 * FS_DIV);
        end

        // Bus reset with tx_valid held high, then the waiting packet
        usb_full_speed = 1'b1;
        pkt.delete();
        pkt.push_back(8'h3C);
        byte_q = pkt;
        m_rst(1'b1);
        m_packet(1'b1);
        m_idle(1'b1);
        run(-1, 0);
        check("bus reset SE0 clks", se0_clks, RST_CYC + 2 * FS_DIV);

        // Low-speed keep-alive from idle
        usb_full_speed = 1'b0;
        m_ka(1'b0);
        m_idle(1'b0);
        run(0, -1);
        check("LS keep-alive SE0 clks", se0_clks, 64);
        check("LS keep-alive d_en clks", en_clks, 96);

        // Keep-alive raised mid-packet runs right after the EOP
        usb_full_speed = 1'b1;
        pkt.delete();
        pkt.push_back(8'h12);
        byte_q = pkt;
        m_packet(1'b1);
        m_ka(1'b1);
        m_idle(1'b1);
        run(20, -1);
        check("packet+keep-alive d_en clks", en_clks, 76 + 12);

        // Reset asserted during DATA bit 3 aborts with no EOP
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = 8'hFF;
        @(negedge clk);
        check("abort pkt ready", bus_if.tx_ready, 1'b1);
        @(posedge clk);
        #1;
        bus_if.tx_valid = 1'b0;
        repeat (44) @(posedge clk);
        #1;
        reset           = 1'b0;
        bus_if.tx_valid = 1'b1;
        @(negedge clk);
        check("active before abort", {bus_if.d_en, busy}, 2'b11);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("outputs after abort", {bus_if.d_en, bus_if.d_o, bus_if.tx_ready, busy}, 5'b0);
        @(posedge clk);
        #1;
        reset           = 1'b1;
        bus_if.tx_valid = 1'b0;
        @(posedge clk);
        #1;
        pkt.delete();
        pkt.push_back(8'hFF);
        byte_q = pkt;
        m_packet(1'b1);
        m_idle(1'b1);
        run(-1, -1);
        check("packet after abort d_en clks", en_clks, 80);

        // Randomized packets, some with a keep-alive request somewhere inside
        for (int r = 0; r < 10; r++) begin
            rfs = ($urandom_range(0, 3) != 0);
            rn  = $urandom_range(1, 3);
            pkt.delete();
            for (int k = 0; k < rn; k++) begin
                pick = $urandom_range(0, 3);
                pkt.push_back(pick == 0 ? 8'hFF : pick == 1 ? 8'h00 : 8'($urandom));
            end
            usb_full_speed = rfs;
            byte_q = pkt;
            m_packet(rfs);
            ka_at = -1;
            if ($urandom_range(0, 1) == 1) begin
                ka_at = $urandom_range(0, exp_q.size() - 1);
                m_ka(rfs);
            end
            m_idle(rfs);
            run(ka_at, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
